lcd_byte_sequencer: RTL and testbench

//  Upstream feeder for the AHB 4-bit LCD nibble writer. Runs the HD44780 4-bit power-on init sequence.

---
 rtl/lcd_byte_sequencer.sv | 237 +++++++++++++++++++++++
 tb/tb_lcd_byte_sequencer.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_byte_sequencer.sv
// Feeds an HD44780 4-bit nibble writer: runs the power-on init sequence, then
// drains a host byte FIFO as high/low nibble pairs with controller execution delays.
`timescale 1ns/1ps
module lcd_byte_sequencer #(
  parameter int FIFO_DEPTH = 16,
  parameter int POR_CYCLES = 750000,
  parameter int INIT_GAP   = 205000,
  parameter int SHORT_GAP  = 5000,
  parameter int CMD_CYCLES = 2000,
  parameter int CLR_CYCLES = 82000,
  parameter int NIB_GAP    = 4
) (
  input  logic                          HCLK,
  input  logic                          HRESETn,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [7:0]                    in_byte,
  input  logic                          in_rs,
  output logic                          nib_valid,
  input  logic                          nib_ready,
  output logic [3:0]                    nib_data,
  output logic                          nib_rs,
  output logic                          init_done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  function automatic int maxOf(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int MAX_DELAY = maxOf(maxOf(maxOf(POR_CYCLES, INIT_GAP), maxOf(SHORT_GAP, CMD_CYCLES + NIB_GAP)),
                                   CLR_CYCLES + NIB_GAP);
  localparam int TW = $clog2(MAX_DELAY + 1);

  typedef logic [TW-1:0] timer_t;

  localparam timer_t T_POR      = timer_t'(POR_CYCLES - 1);
  localparam timer_t T_NIB      = timer_t'(NIB_GAP);
  localparam timer_t T_CMD_POST = timer_t'(NIB_GAP + CMD_CYCLES);
  localparam timer_t T_CLR_POST = timer_t'(NIB_GAP + CLR_CYCLES);
  localparam logic [3:0] LAST_STEP = 4'd9;

  typedef enum logic [2:0] {
    POR_WAIT, INIT_NIB, INIT_WAIT, IDLE, SEND_HI, HI_GAP, SEND_LO, POST_WAIT
  } state_t;

  state_t        state_q, state_d;
  timer_t        timer_q, timer_d;
  logic [3:0]    step_q, step_d;
  logic [7:0]    hold_q, hold_d;
  logic          holdRs_q, holdRs_d;
  logic          initDone_q, initDone_d;
  logic          porArmed_q, porArmed_d;

  logic [8:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wrPtr_q, rdPtr_q;
  logic [LW-1:0] level_q, level_d;
  logic          inReady_q;
  logic          push, pop;

  // Steps 0..3 are the bare init nibbles, steps 4..8 the configuration bytes.
  function automatic timer_t initGap(input logic [3:0] s);
    case (s)
      4'd0:    return timer_t'(INIT_GAP);
      4'd1:    return timer_t'(SHORT_GAP);
      default: return timer_t'(CMD_CYCLES);
    endcase
  endfunction

  function automatic logic [7:0] initByte(input logic [3:0] s);
    case (s)
      4'd4:    return 8'h28;
      4'd5:    return 8'h08;
      4'd6:    return 8'h01;
      4'd7:    return 8'h06;
      default: return 8'h0C;
    endcase
  endfunction

  assign push = in_valid && inReady_q;

  always_comb begin
    level_d = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (push) mem[wrPtr_q] <= {in_rs, in_byte};
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      wrPtr_q   <= '0;
      rdPtr_q   <= '0;
      level_q   <= '0;
      inReady_q <= 1'b0;
    end else begin
      if (push) wrPtr_q <= wrPtr_q + AW'(1);
      if (pop)  rdPtr_q <= rdPtr_q + AW'(1);
      level_q   <= level_d;
      inReady_q <= (level_d != LW'(FIFO_DEPTH));
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q    <= POR_WAIT;
      timer_q    <= '0;
      step_q     <= '0;
      hold_q     <= '0;
      holdRs_q   <= 1'b0;
      initDone_q <= 1'b0;
      porArmed_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      step_q     <= step_d;
      hold_q     <= hold_d;
      holdRs_q   <= holdRs_d;
      initDone_q <= initDone_d;
      porArmed_q <= porArmed_d;
    end
  end

  // Every wait state leaves on its last counted cycle, so a load of N gives N idle cycles.
  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    step_d     = step_q;
    hold_d     = hold_q;
    holdRs_d   = holdRs_q;
    initDone_d = initDone_q;
    porArmed_d = porArmed_q;
    pop        = 1'b0;
    case (state_q)
      POR_WAIT: begin
        if (!porArmed_q) begin
          porArmed_d = 1'b1;
          if (POR_CYCLES <= 1) state_d = INIT_NIB;
          else                 timer_d = T_POR;
        end else if (timer_q <= timer_t'(1)) begin
          state_d = INIT_NIB;
        end else begin
          timer_d = timer_q - timer_t'(1);
        end
      end
      INIT_NIB: begin
        if (nib_ready) begin
          timer_d = initGap(step_q);
          step_d  = step_q + 4'd1;
          state_d = INIT_WAIT;
        end
      end
      INIT_WAIT: begin
        if (timer_q <= timer_t'(1)) state_d = (step_q < 4'd4) ? INIT_NIB : IDLE;
        else                        timer_d = timer_q - timer_t'(1);
      end
      IDLE: begin
        if (initDone_q) begin
          if (level_q != '0) begin
            pop      = 1'b1;
            hold_d   = mem[rdPtr_q][7:0];
            holdRs_d = mem[rdPtr_q][8];
            state_d  = SEND_HI;
          end
        end else begin
          hold_d   = initByte(step_q);
          holdRs_d = 1'b0;
          step_d   = step_q + 4'd1;
          state_d  = SEND_HI;
        end
      end
      SEND_HI: begin
        if (nib_ready) begin
          timer_d = T_NIB;
          state_d = HI_GAP;
        end
      end
      HI_GAP: begin
        if (timer_q <= timer_t'(1)) state_d = SEND_LO;
        else                        timer_d = timer_q - timer_t'(1);
      end
      SEND_LO: begin
        if (nib_ready) begin
          // Clear display / return home run far longer than any other instruction.
          if (!holdRs_q && hold_q[7:2] == 6'd0 && hold_q != 8'd0) timer_d = T_CLR_POST;
          else                                                     timer_d = T_CMD_POST;
          state_d = POST_WAIT;
        end
      end
      POST_WAIT: begin
        if (timer_q <= timer_t'(1)) begin
          state_d = IDLE;
          if (!initDone_q && step_q == LAST_STEP) initDone_d = 1'b1;
        end else begin
          timer_d = timer_q - timer_t'(1);
        end
      end
      default: state_d = POR_WAIT;
    endcase
  end

  always_comb begin
    nib_valid = 1'b0;
    nib_data  = 4'h0;
    nib_rs    = 1'b0;
    case (state_q)
      INIT_NIB: begin
        nib_valid = 1'b1;
        nib_data  = (step_q == 4'd3) ? 4'h2 : 4'h3;
      end
      SEND_HI: begin
        nib_valid = 1'b1;
        nib_data  = hold_q[7:4];
        nib_rs    = holdRs_q;
      end
      SEND_LO: begin
        nib_valid = 1'b1;
        nib_data  = hold_q[3:0];
        nib_rs    = holdRs_q;
      end
      default: ;
    endcase
  end

  assign in_ready   = inReady_q;
  assign init_done  = initDone_q;
  assign fifo_level = level_q;

endmodule

// File: tb/tb_lcd_byte_sequencer.sv
// Directed bench for lcd_byte_sequencer using shortened delays; a negedge monitor
// logs every nibble handshake with its cycle number for timing checks.
`timescale 1ns/1ps
module tb_lcd_byte_sequencer;

  localparam int DEPTH = 4;

  logic       HCLK = 1'b0;
  logic       HRESETn = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_byte = 8'h00;
  logic       in_rs = 1'b0;
  logic       nib_ready = 1'b0;
  logic       in_ready, nib_valid, nib_rs, init_done;
  logic [3:0] nib_data;
  logic [2:0] fifo_level;

  lcd_byte_sequencer #(
    .FIFO_DEPTH(DEPTH), .POR_CYCLES(10), .INIT_GAP(8), .SHORT_GAP(6),
    .CMD_CYCLES(4), .CLR_CYCLES(12), .NIB_GAP(2)
  ) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .in_valid(in_valid), .in_ready(in_ready),
    .in_byte(in_byte), .in_rs(in_rs), .nib_valid(nib_valid), .nib_ready(nib_ready),
    .nib_data(nib_data), .nib_rs(nib_rs), .init_done(init_done), .fifo_level(fifo_level)
  );

  always #5 HCLK = ~HCLK;

  int cycCnt = 0;
  always @(posedge HCLK) cycCnt <= cycCnt + 1;

  typedef struct {
    int         cyc;
    logic [3:0] d;
    logic       rs;
  } xfer_t;

  xfer_t xq[$];
  int    doneCyc = 0;
  bit    doneSeen = 1'b0;
  int    vectors = 0;
  int    miscompares = 0;
  int    baseCyc = 0;

  // Expected init nibbles and the cycle distance from the previous transfer
  // (entry 0 is measured from reset release).
  logic [3:0] initNib  [14] = '{4'h3, 4'h3, 4'h3, 4'h2, 4'h2, 4'h8, 4'h0, 4'h8, 4'h0, 4'h1, 4'h0, 4'h6, 4'h0, 4'hC};
  int         initDiff [14] = '{10, 9, 7, 5, 6, 3, 8, 3, 8, 3, 16, 3, 8, 3};

  always @(negedge HCLK) begin
    if (!HRESETn) begin
      xq.delete();
      doneSeen = 1'b0;
    end else begin
      if (nib_valid && nib_ready) xq.push_back('{cyc: cycCnt, d: nib_data, rs: nib_rs});
      if (init_done && !doneSeen) begin
        doneSeen = 1'b1;
        doneCyc  = cycCnt;
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge HCLK);
    #1;
  endtask

  task automatic applyStimulus(input logic [7:0] b, input logic rs);
    in_valid = 1'b1;
    in_byte  = b;
    in_rs    = rs;
    @(posedge HCLK);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic waitXfers(input int n, input int budget);
    int k = 0;
    while (xq.size() < n && k < budget) begin
      @(negedge HCLK);
      k++;
    end
    checkOutput($sformatf("xfer count %0d", n), xq.size(), n);
  endtask

  task automatic checkXfer(input int idx, input logic [3:0] expD, input logic expRs, input int expDiff);
    int diff;
    if (idx >= xq.size()) begin
      checkOutput($sformatf("xfer%0d present", idx), xq.size(), idx + 1);
    end else begin
      checkOutput($sformatf("xfer%0d data", idx), xq[idx].d, expD);
      checkOutput($sformatf("xfer%0d rs", idx), xq[idx].rs, expRs);
      if (expDiff >= 0) begin
        diff = (idx == 0) ? xq[0].cyc - baseCyc : xq[idx].cyc - xq[idx-1].cyc;
        checkOutput($sformatf("xfer%0d spacing", idx), diff, expDiff);
      end
    end
  endtask

  task automatic checkInit(input bit checkStart);
    for (int i = 0; i < 14; i++)
      checkXfer(i, initNib[i], 1'b0, (i == 0 && !checkStart) ? -1 : initDiff[i]);
    repeat (10) @(negedge HCLK);
    checkOutput("init_done delay", (doneSeen && xq.size() >= 14) ? doneCyc - xq[13].cyc : -1, 7);
    checkOutput("init_done level", init_done, 1'b1);
    @(posedge HCLK);
    #1;
  endtask

  task automatic checkResetOutputs(input string phase);
    checkOutput({phase, " in_ready"}, in_ready, 1'b0);
    checkOutput({phase, " nib_valid"}, nib_valid, 1'b0);
    checkOutput({phase, " nib_data"}, nib_data, 4'h0);
    checkOutput({phase, " nib_rs"}, nib_rs, 1'b0);
    checkOutput({phase, " init_done"}, init_done, 1'b0);
    checkOutput({phase, " fifo_level"}, fifo_level, 3'd0);
  endtask

  initial begin
    int stable;
    int k;

    // Power-on init with the writer always ready.
    nib_ready = 1'b1;
    waitCycles(3);
    checkResetOutputs("por");
    HRESETn = 1'b1;
    baseCyc = cycCnt;
    waitXfers(14, 300);
    checkInit(1'b1);
    checkOutput("post-init in_ready", in_ready, 1'b1);
    checkOutput("post-init xfers", xq.size(), 14);

    // Data byte 0x41 followed by 0x30, the second pushed in the pop cycle.
    xq.delete();
    baseCyc = cycCnt;
    applyStimulus(8'h41, 1'b1);
    applyStimulus(8'h30, 1'b1);
    checkOutput("push+pop level", fifo_level, 3'd1);
    waitXfers(4, 100);
    checkXfer(0, 4'h4, 1'b1, 2);
    checkXfer(1, 4'h1, 1'b1, 3);
    checkXfer(2, 4'h3, 1'b1, 8);
    checkXfer(3, 4'h0, 1'b1, 3);
    waitCycles(20);

    // Clear-display command stretches the following gap.
    xq.delete();
    baseCyc = cycCnt;
    applyStimulus(8'h01, 1'b0);
    applyStimulus(8'h42, 1'b1);
    waitXfers(4, 100);
    checkXfer(0, 4'h0, 1'b0, 2);
    checkXfer(1, 4'h1, 1'b0, 3);
    checkXfer(2, 4'h4, 1'b1, 16);
    checkXfer(3, 4'h2, 1'b1, 3);
    waitCycles(20);

    // Writer stalls the low nibble for 20 cycles.
    xq.delete();
    applyStimulus(8'h9A, 1'b1);
    waitXfers(1, 50);
    @(posedge HCLK);
    #1;
    nib_ready = 1'b0;
    k = 0;
    do begin
      @(negedge HCLK);
      k++;
    end while (!nib_valid && k < 10);
    stable = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge HCLK);
      if (nib_valid === 1'b1 && nib_data === 4'hA && nib_rs === 1'b1) stable++;
    end
    checkOutput("stall stable cycles", stable, 20);
    checkOutput("stall xfers", xq.size(), 1);
    @(posedge HCLK);
    #1;
    nib_ready = 1'b1;
    waitCycles(10);
    checkOutput("stall release xfers", xq.size(), 2);
    checkXfer(1, 4'hA, 1'b1, -1);
    waitCycles(20);

    // Asynchronous reset in POST_WAIT with two bytes still queued.
    xq.delete();
    applyStimulus(8'h11, 1'b1);
    applyStimulus(8'h22, 1'b1);
    applyStimulus(8'h33, 1'b1);
    waitXfers(2, 100);
    @(posedge HCLK);
    #1;
    checkOutput("queued level", fifo_level, 3'd2);
    HRESETn = 1'b0;
    #1;
    checkResetOutputs("mid-reset");
    waitCycles(2);
    HRESETn = 1'b1;
    baseCyc = cycCnt;
    waitXfers(14, 300);
    checkInit(1'b1);
    waitCycles(20);
    checkOutput("rerun xfers", xq.size(), 14);
    checkOutput("rerun level", fifo_level, 3'd0);

    // Fill the FIFO while init is stalled, overflow by one, then drain.
    HRESETn = 1'b0;
    nib_ready = 1'b0;
    waitCycles(2);
    HRESETn = 1'b1;
    baseCyc = cycCnt;
    waitCycles(1);
    checkOutput("empty in_ready", in_ready, 1'b1);
    applyStimulus(8'hA1, 1'b1);
    applyStimulus(8'hB2, 1'b1);
    applyStimulus(8'hC3, 1'b1);
    applyStimulus(8'hD4, 1'b1);
    applyStimulus(8'hE5, 1'b1);
    checkOutput("full in_ready", in_ready, 1'b0);
    checkOutput("full level", fifo_level, 3'd4);
    waitCycles(15);
    checkOutput("stalled init valid", nib_valid, 1'b1);
    checkOutput("stalled init data", nib_data, 4'h3);
    checkOutput("stalled xfers", xq.size(), 0);
    nib_ready = 1'b1;
    waitXfers(22, 600);
    checkInit(1'b0);
    checkXfer(14, 4'hA, 1'b1, 8);
    checkXfer(15, 4'h1, 1'b1, 3);
    checkXfer(16, 4'hB, 1'b1, 8);
    checkXfer(17, 4'h2, 1'b1, 3);
    checkXfer(18, 4'hC, 1'b1, 8);
    checkXfer(19, 4'h3, 1'b1, 3);
    checkXfer(20, 4'hD, 1'b1, 8);
    checkXfer(21, 4'h4, 1'b1, 3);
    waitCycles(30);
    checkOutput("overflow dropped", xq.size(), 22);
    checkOutput("drained level", fifo_level, 3'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
